dma_multi: RTL and testbench
============================

# dma_multi

Parametrised multi-channel memory-to-memory DMA engine with an internal register-array memory. Each of NCH channels accepts a descriptor (source, destination, length, mode) and runs independently. A round-robin arbiter grants one word transfer per cycle. A host write port loads the memory, and completion is reported per channel as a one-cycle pulse. The block sits directly behind the top-level pin wrapper and generalises the single-channel tiny DMA core.

## Interface
- DW, 7: data word width.
- AW, 3: address width; memory depth DEPTH = 2^AW.
- NCH, 2: number of channels (2..8).
- LW, 3: length field width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  descriptor offered.
- req_ready  out  1  descriptor accepted when high with req_valid; equals !busy[req_ch].
- req_ch  in  $clog2(NCH)  target channel.
- req_src, req_dst  in  AW  start addresses.
- req_len  in  LW  word count.
- req_fix_src  in  1  1 = source address held constant (fill mode); 0 = increment.
- abort  in  NCH  per-channel abort strobe.
- wr_en  in  1  host memory write.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- busy  out  NCH  channel has a descriptor in progress.
- done  out  NCH  one-cycle completion pulse per channel.
- data_out  out  DW  last word transferred.
- grant_ch  out  $clog2(NCH)  channel served by the last transfer.

## Operation
- Per channel: IDLE -> ACTIVE on accepted request with req_len != 0. ACTIVE -> IDLE after the last word, or on abort.
- A request with req_len == 0 is accepted. No transfer occurs, busy stays low, and done[ch] pulses on the next cycle.
- Transfer cycle: occurs when any channel is ACTIVE and wr_en == 0.
  - Arbiter picks the first ACTIVE channel after the last-granted one, ascending modulo NCH.
  - mem[dst] <= mem[src], where mem[src] is the pre-edge value, so overlapping ranges copy old data.
  - data_out <= mem[src] and grant_ch <= ch.
  - dst increments. src increments unless fix_src. Both wrap modulo DEPTH.
  - len decrements.
- Host write: takes priority. mem[wr_addr] <= wr_data, and no DMA transfer happens that cycle; the arbiter pointer does not advance.
- Abort[ch]:
  - If ACTIVE: the channel returns to IDLE immediately. A transfer granted to it in that cycle is suppressed, and done is not pulsed.
  - If IDLE: abort is ignored, and a same-cycle request to that channel is accepted.
- A request to a busy channel is not accepted (req_ready low). Descriptors of other channels are unaffected.
- Memory reset values: mem[i] = (0x61 + i) truncated to DW for i < 4, and 0 otherwise.

## Timing
- Reset values: busy = 0, done = 0, data_out = 0, grant_ch = 0, req_ready = 1, and all channels IDLE. The arbiter's last-granted pointer resets to NCH-1, so channel 0 wins first.
- Request latency: a descriptor accepted at edge k makes its first transfer earliest at edge k+1.
- done[ch] is high for exactly the cycle following the edge that commits the channel's last word. busy[ch] falls on that same edge.
- Throughput: one word per cycle in aggregate. With N active channels, each channel gets one word per N cycles.
- A channel freed at edge k may accept a new descriptor in cycle k (req_ready is combinational on busy).
- Reset asserted mid-transfer: all state clears asynchronously, including memory contents. No done pulse is generated.

## Structure
- Package dma_pkg holds:
  - default parameter values;
  - the channel state encoding (CH_IDLE, CH_ACTIVE);
  - a descriptor struct typedef {src, dst, len, fix_src}.
- Sub-module rr_arbiter (parameter N) takes a request vector and an advance enable, and outputs a one-hot grant and an index.
- The top contains the descriptor registers, the memory array and the datapath.

## Test plan
- Reset, then request ch0 src=0 dst=4 len=3 fix_src=0 -> data_out 0x61, 0x62, 0x63 on successive cycles; mem[4..6] = 0x61..0x63; done[0] pulses once, 3 cycles after acceptance.
- Ch0 src=0 dst=4 len=4 and ch1 src=2 dst=6 len=2 accepted the same or adjacent cycles -> grant_ch alternates 0,1,0,1,0,0; each done pulses once.
- Fill mode: src=1 dst=3 len=5 fix_src=1 -> mem[3..7] = 0x62; dst wraps to 0 for no writes beyond 5 words.
- Wrap: src=6 dst=7 len=3 -> copies mem[6], mem[7], mem[0] into 7, 0, 1 using pre-edge data.
- Abort ch0 after 1 of 3 words -> busy[0] drops, no done, only one word written; a new request on ch0 is accepted the next cycle.
- wr_en held for 2 cycles during an active transfer -> transfer stalls 2 cycles, host data lands, and the DMA result is otherwise unchanged. A len=0 request -> done pulses the next cycle with no memory change.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared defaults, channel state encoding and descriptor layout for the
// multi-channel DMA engine.
package dma_pkg;

  localparam int DMA_DW  = 7;
  localparam int DMA_AW  = 3;
  localparam int DMA_NCH = 2;
  localparam int DMA_LW  = 3;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [DMA_AW-1:0] src;
    logic [DMA_AW-1:0] dst;
    logic [DMA_LW-1:0] len;
    logic              fix_src;
  } desc_t;

  // Power-up memory image: a short ASCII-like ramp in the first four words.
  function automatic logic [7:0] mem_init_val(input int idx);
    logic [7:0] v;
    if (idx < 4) begin
      v = 8'h61 + 8'(idx);
    end else begin
      v = 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/dma_multi_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last-granted
// index; the pointer only moves when the caller says the grant was used.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_grant,
  output logic [IW-1:0] o_idx,
  output logic         o_valid
);

  logic [IW-1:0] r_last;

  // Search downwards so the nearest requester after r_last is assigned last and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[IW'((int'(r_last) + k) % N)]) begin
        o_grant = '0;
        o_grant[IW'((int'(r_last) + k) % N)] = 1'b1;
        o_idx   = IW'((int'(r_last) + k) % N);
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

  // Last-granted pointer; reset to N-1 so index 0 has first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= IW'(N - 1);
    end else if (i_adv && o_valid) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/dma_multi.sv
// Multi-channel memory-to-memory DMA over an internal register-array memory;
// one word per cycle shared round-robin, host writes take priority.
module dma_multi
  import dma_pkg::*;
#(
  parameter  int DW    = DMA_DW,
  parameter  int AW    = DMA_AW,
  parameter  int NCH   = DMA_NCH,
  parameter  int LW    = DMA_LW,
  localparam int CW    = $clog2(NCH),
  localparam int DEPTH = 2 ** AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic [CW-1:0]  i_req_ch,
  input  logic [AW-1:0]  i_req_src,
  input  logic [AW-1:0]  i_req_dst,
  input  logic [LW-1:0]  i_req_len,
  input  logic           i_req_fix_src,
  input  logic [NCH-1:0] i_abort,
  input  logic           i_wr_en,
  input  logic [AW-1:0]  i_wr_addr,
  input  logic [DW-1:0]  i_wr_data,
  output logic [NCH-1:0] o_busy,
  output logic [NCH-1:0] o_done,
  output logic [DW-1:0]  o_data_out,
  output logic [CW-1:0]  o_grant_ch
);

  ch_state_e      r_state     [NCH];
  ch_state_e      w_state_nxt [NCH];
  desc_t          r_desc      [NCH];
  desc_t          w_desc_nxt  [NCH];
  logic [DW-1:0]  r_mem       [DEPTH];

  logic [NCH-1:0] w_active;
  logic [NCH-1:0] w_gnt_oh;
  logic [NCH-1:0] w_done_nxt;
  logic [NCH-1:0] r_done;
  logic [CW-1:0]  w_gidx;
  logic           w_gvalid;
  logic           w_xfer;
  logic           w_commit;
  logic [AW-1:0]  w_src;
  logic [AW-1:0]  w_dst;
  logic [DW-1:0]  w_word;
  logic [DW-1:0]  r_data_out;
  logic [CW-1:0]  r_grant_ch;

  // Active-channel vector feeds both the arbiter and the busy outputs.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NCH; i++) begin
      w_active[i] = (r_state[i] == CH_ACTIVE);
    end
  end

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_active),
    .i_adv   (w_xfer),
    .o_grant (w_gnt_oh),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  // The pointer advances on any transfer slot; an abort only cancels the data movement.
  assign w_xfer   = w_gvalid & ~i_wr_en;
  assign w_commit = w_xfer & ~i_abort[w_gidx];
  assign w_src    = r_desc[w_gidx].src;
  assign w_dst    = r_desc[w_gidx].dst;
  assign w_word   = r_mem[w_src];

  // Per-channel next state: accept when idle, otherwise abort or advance on a committed grant.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_desc_nxt[i]  = r_desc[i];
      w_done_nxt[i]  = 1'b0;
      case (r_state[i])
        CH_IDLE: begin
          if (i_req_valid && (i_req_ch == CW'(i))) begin
            w_desc_nxt[i] = '{src: i_req_src, dst: i_req_dst,
                              len: i_req_len, fix_src: i_req_fix_src};
            if (i_req_len != LW'(0)) begin
              w_state_nxt[i] = CH_ACTIVE;
            end else begin
              w_done_nxt[i] = 1'b1;
            end
          end else begin
            w_state_nxt[i] = CH_IDLE;
          end
        end
        CH_ACTIVE: begin
          if (i_abort[i]) begin
            w_state_nxt[i] = CH_IDLE;
          end else if (w_commit && w_gnt_oh[i]) begin
            w_desc_nxt[i].dst = r_desc[i].dst + AW'(1);
            w_desc_nxt[i].src = r_desc[i].fix_src ? r_desc[i].src : r_desc[i].src + AW'(1);
            w_desc_nxt[i].len = r_desc[i].len - LW'(1);
            if (r_desc[i].len == LW'(1)) begin
              w_state_nxt[i] = CH_IDLE;
              w_done_nxt[i]  = 1'b1;
            end else begin
              w_state_nxt[i] = CH_ACTIVE;
            end
          end else begin
            w_state_nxt[i] = CH_ACTIVE;
          end
        end
        default: begin
          w_state_nxt[i] = CH_IDLE;
        end
      endcase
    end
  end

  // Channel state and descriptor registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= CH_IDLE;
        r_desc[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_desc[i]  <= w_desc_nxt[i];
      end
    end
  end

  // Memory array: host write wins, otherwise the committed DMA word lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DW'(mem_init_val(i));
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end else if (w_commit) begin
      r_mem[w_dst] <= w_word;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done     <= '0;
      r_data_out <= '0;
      r_grant_ch <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_commit) begin
        r_data_out <= w_word;
        r_grant_ch <= w_gidx;
      end
    end
  end

  assign o_busy      = w_active;
  assign o_done      = r_done;
  assign o_data_out  = r_data_out;
  assign o_grant_ch  = r_grant_ch;
  assign o_req_ready = ~w_active[i_req_ch];

endmodule

// File: tb/tb_dma_multi.sv
// Randomised and directed bench for dma_multi against a word-level model of
// the channel descriptors, shared memory and round-robin pointer.
module tb_dma_multi;
  localparam int DW = 7, AW = 3, NCH = 2, LW = 3;
  localparam int CW = $clog2(NCH), DEPTH = 2 ** AW;

  logic clk = 1'b0, rst = 1'b0;
  logic i_req_valid, i_req_fix_src, i_wr_en, o_req_ready;
  logic [CW-1:0] i_req_ch, o_grant_ch;
  logic [AW-1:0] i_req_src, i_req_dst, i_wr_addr;
  logic [LW-1:0] i_req_len;
  logic [NCH-1:0] i_abort, o_busy, o_done;
  logic [DW-1:0] i_wr_data, o_data_out;

  dma_multi #(.DW(DW), .AW(AW), .NCH(NCH), .LW(LW)) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_ch(i_req_ch), .i_req_src(i_req_src), .i_req_dst(i_req_dst),
    .i_req_len(i_req_len), .i_req_fix_src(i_req_fix_src), .i_abort(i_abort),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_data_out(o_data_out), .o_grant_ch(o_grant_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bit run_cmp = 1'b0;

  // Model state (m_) and the value it takes after the coming edge (n_).
  int m_mem [DEPTH], n_mem [DEPTH];
  bit m_act [NCH], n_act [NCH], m_fix [NCH], n_fix [NCH];
  int m_src [NCH], n_src [NCH], m_dst [NCH], n_dst [NCH], m_len [NCH], n_len [NCH];
  int m_last, n_last, m_data, n_data, m_gch, n_gch;
  bit [NCH-1:0] m_done, n_done;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = (a < 4) ? ((8'h61 + a) & ((1 << DW) - 1)) : 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 1'b0; m_fix[c] = 1'b0; m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0;
    end
    m_last = NCH - 1; m_data = 0; m_gch = 0; m_done = '0;
  endtask

  task automatic model_next();
    int g;
    n_mem = m_mem; n_act = m_act; n_fix = m_fix; n_src = m_src; n_dst = m_dst; n_len = m_len;
    n_last = m_last; n_data = m_data; n_gch = m_gch; n_done = '0;
    if (i_wr_en) begin
      n_mem[int'(i_wr_addr)] = int'(i_wr_data);
    end else begin
      g = -1;
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && m_act[(m_last + k) % NCH]) g = (m_last + k) % NCH;
      if (g >= 0) begin
        n_last = g;
        if (!i_abort[g]) begin
          n_mem[m_dst[g]] = m_mem[m_src[g]];
          n_data = m_mem[m_src[g]];
          n_gch = g;
          n_dst[g] = (m_dst[g] + 1) % DEPTH;
          if (!m_fix[g]) n_src[g] = (m_src[g] + 1) % DEPTH;
          n_len[g] = m_len[g] - 1;
          if (n_len[g] == 0) begin n_act[g] = 1'b0; n_done[g] = 1'b1; end
        end
      end
    end
    for (int c = 0; c < NCH; c++) if (m_act[c] && i_abort[c]) n_act[c] = 1'b0;
    if (i_req_valid && !m_act[int'(i_req_ch)]) begin
      if (i_req_len == '0) n_done[int'(i_req_ch)] = 1'b1;
      else begin
        n_act[int'(i_req_ch)] = 1'b1; n_fix[int'(i_req_ch)] = i_req_fix_src;
        n_src[int'(i_req_ch)] = int'(i_req_src); n_dst[int'(i_req_ch)] = int'(i_req_dst);
        n_len[int'(i_req_ch)] = int'(i_req_len);
      end
    end
  endtask

  // One clock: predict, take the edge, adopt the prediction.
  task automatic cyc();
    model_next();
    @(posedge clk); #1;
    m_mem = n_mem; m_act = n_act; m_fix = n_fix; m_src = n_src; m_dst = n_dst; m_len = n_len;
    m_last = n_last; m_data = n_data; m_gch = n_gch; m_done = n_done;
  endtask

  task automatic idle();
    i_req_valid = 1'b0; i_req_ch = '0; i_req_src = '0; i_req_dst = '0; i_req_len = '0;
    i_req_fix_src = 1'b0; i_abort = '0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
  endtask

  task automatic req(input int ch, input int src, input int dst, input int len, input int fix);
    i_req_valid = 1'b1; i_req_ch = CW'(ch); i_req_src = AW'(src); i_req_dst = AW'(dst);
    i_req_len = LW'(len); i_req_fix_src = (fix != 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_data", int'(o_data_out), 0);
    check("rst_grant", int'(o_grant_ch), 0);
    check("rst_ready", int'(o_req_ready), 1);
  endtask

  function automatic int model_busy();
    int b = 0;
    for (int c = 0; c < NCH; c++) if (m_act[c]) b |= (1 << c);
    return b;
  endfunction

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("busy", int'(o_busy), model_busy());
      check("done", int'(o_done), int'(m_done));
      check("data_out", int'(o_data_out), m_data);
      check("grant_ch", int'(o_grant_ch), m_gch);
      check("req_ready", int'(o_req_ready), m_act[int'(i_req_ch)] ? 0 : 1);
    end
  end

  int gexp [6] = '{0, 1, 0, 1, 0, 0};

  initial begin
    idle();
    do_reset();
    run_cmp = 1'b1;

    // Plain copy 0..2 -> 4..6, then read 4..6 back by an in-place copy.
    req(0, 0, 4, 3, 0); cyc(); idle();
    cyc(); check("s1_w0", int'(o_data_out), 'h61);
    cyc(); check("s1_w1", int'(o_data_out), 'h62);
    cyc(); check("s1_w2", int'(o_data_out), 'h63);
    check("s1_done", int'(o_done), 'b01);
    cyc(); check("s1_done_low", int'(o_done), 0);
    req(0, 4, 4, 3, 0); cyc(); idle();
    cyc(); check("s1_rb0", int'(o_data_out), 'h61);
    cyc(); check("s1_rb1", int'(o_data_out), 'h62);
    cyc(); check("s1_rb2", int'(o_data_out), 'h63);

    // Two channels sharing the slot.
    do_reset();
    req(0, 0, 4, 4, 0); cyc();
    req(1, 2, 6, 2, 0); cyc(); idle();
    check("s2_g0", int'(o_grant_ch), gexp[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(); check("s2_grant", int'(o_grant_ch), gexp[i]);
      if (i == 3) check("s2_done1", int'(o_done), 'b10);
      if (i == 5) check("s2_done0", int'(o_done), 'b01);
    end

    // Fill mode with destination wrap.
    do_reset();
    req(0, 1, 3, 5, 1); cyc(); idle();
    for (int i = 0; i < 5; i++) begin cyc(); check("s3_fill", int'(o_data_out), 'h62); end
    check("s3_done", int'(o_done), 'b01);
    req(1, 3, 3, 5, 0); cyc(); idle();
    for (int i = 0; i < 5; i++) begin cyc(); check("s3_rb", int'(o_data_out), 'h62); end

    // Address wrap reading data written on the previous edge.
    do_reset();
    i_wr_en = 1'b1; i_wr_addr = 3'd6; i_wr_data = 7'h11; cyc();
    i_wr_addr = 3'd7; i_wr_data = 7'h22; cyc(); idle();
    req(0, 6, 7, 3, 0); cyc(); idle();
    for (int i = 0; i < 3; i++) begin cyc(); check("s4_wrap", int'(o_data_out), 'h11); end

    // Abort after one word, then immediate reuse of the channel.
    do_reset();
    req(0, 0, 4, 3, 0); cyc(); idle();
    cyc(); check("s5_w0", int'(o_data_out), 'h61);
    i_abort = 2'b01; cyc(); idle();
    check("s5_busy", int'(o_busy), 0);
    check("s5_nodone", int'(o_done), 0);
    check("s5_ready", int'(o_req_ready), 1);
    req(0, 4, 4, 2, 0); cyc(); idle();
    check("s5_reuse", int'(o_busy), 'b01);
    cyc(); check("s5_rb0", int'(o_data_out), 'h61);
    cyc(); check("s5_rb1", int'(o_data_out), 0);

    // Host writes stall the transfer; zero-length request.
    do_reset();
    req(0, 0, 4, 3, 0); cyc(); idle();
    cyc(); check("s6_w0", int'(o_data_out), 'h61);
    i_wr_en = 1'b1; i_wr_addr = 3'd7; i_wr_data = 7'h55; cyc();
    check("s6_stall", int'(o_data_out), 'h61);
    i_wr_data = 7'h56; cyc(); idle();
    check("s6_stall_busy", int'(o_busy), 'b01);
    cyc(); check("s6_w1", int'(o_data_out), 'h62);
    cyc(); check("s6_w2", int'(o_data_out), 'h63);
    req(1, 0, 0, 0, 0); cyc(); idle();
    check("s6_len0_done", int'(o_done), 'b10);
    check("s6_len0_busy", int'(o_busy), 0);
    req(0, 7, 7, 1, 0); cyc(); idle();
    cyc(); check("s6_host", int'(o_data_out), 'h56);

    // Random traffic including aborts, host writes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        i_req_valid = ($urandom_range(0, 2) == 0);
        i_req_ch = CW'($urandom_range(0, NCH - 1));
        i_req_src = AW'($urandom_range(0, DEPTH - 1));
        i_req_dst = AW'($urandom_range(0, DEPTH - 1));
        i_req_len = LW'($urandom_range(0, 7));
        i_req_fix_src = ($urandom_range(0, 3) == 0);
        for (int c = 0; c < NCH; c++) i_abort[c] = ($urandom_range(0, 19) == 0);
        i_wr_en = ($urandom_range(0, 4) == 0);
        i_wr_addr = AW'($urandom_range(0, DEPTH - 1));
        i_wr_data = DW'($urandom_range(0, (1 << DW) - 1));
        cyc();
      end
    end
    idle();
    @(negedge clk);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
